glitch_player: RTL and testbench

Consumer side of the 32-bit glitch descriptor FIFO. It pops descriptors on the FIFO read port, waits for an external trigger, then drives a cycle-accurate glitch pulse train on `GLITCH`. Each pulse has a programmable delay and width. The block sits between the FIFO read port and the output pin logic, and runs on the FIFO read clock.

---
 rtl/glitch_pkg.sv | 26 ++
 rtl/glitch_trig_edge.sv | 39 +++
 rtl/glitch_player.sv | 136 +++++++++++++
 tb/tb_glitch_player.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types for the glitch descriptor player: FSM states, descriptor field
// positions and the packed descriptor layout.
package glitch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StWaitTrig,
        StDelay,
        StPulse
    } state_t;

    localparam int unsigned DELAY_MSB = 31;
    localparam int unsigned DELAY_LSB = 16;
    localparam int unsigned WIDTH_MSB = 15;
    localparam int unsigned WIDTH_LSB = 1;
    localparam int unsigned LAST_BIT  = 0;

    typedef struct packed {
        logic [DELAY_MSB-DELAY_LSB:0] delay;
        logic [WIDTH_MSB-WIDTH_LSB:0] width;
        logic                         last;
    } desc_t;

endpackage

// File: rtl/glitch_trig_edge.sv
// Trigger rising-edge detector producing a one-cycle pulse.
// GLITCH_TRIG_SYNC_EN adds a two-flop synchronizer ahead of the detector.
module glitch_trig_edge (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pulse
);

    logic trig_s;
    logic prev_q;

`ifdef GLITCH_TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], trig};
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = trig;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= trig_s;
        end
    end

    assign pulse = trig_s & ~prev_q;

endmodule

// File: rtl/glitch_player.sv
// Pops glitch descriptors from the FIFO read port and plays a delay/width pulse
// train on GLITCH after a trigger edge. GLITCH_TRIG_SYNC_EN: see glitch_trig_edge.
module glitch_player
    import glitch_pkg::*;
#(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned WIDTH_W = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ARM,
    input  logic        TRIGGER,
    input  logic        ABORT,
    input  logic [31:0] FIFO_Q,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RE,
    output logic        GLITCH,
    output logic        BUSY,
    output logic        DONE,
    output logic        UNDERRUN
);

    state_t               state_q;
    desc_t                desc_q;
    logic [DELAY_W-1:0]   cnt_q;
    logic                 first_q;
    logic                 trig_pulse;
    logic [DELAY_W-1:0]   fifo_delay;
    logic [DELAY_W-1:0]   desc_delay;
    logic [WIDTH_W-1:0]   desc_width;
    logic                 seq_end;

    glitch_trig_edge u_trig_edge (
        .clk   (CLOCK),
        .rst   (RESET),
        .trig  (TRIGGER),
        .pulse (trig_pulse)
    );

    assign fifo_delay = FIFO_Q[DELAY_LSB +: DELAY_W];
    assign desc_delay = desc_q[DELAY_LSB +: DELAY_W];
    assign desc_width = desc_q[WIDTH_LSB +: WIDTH_W];

    // End of the current descriptor: pulse finished, or zero-width delay expired.
    assign seq_end = (cnt_q == '0) &&
                     ((state_q == StPulse) || ((state_q == StDelay) && (desc_width == '0)));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= StIdle;
            desc_q   <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            FIFO_RE  <= 1'b0;
            GLITCH   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            UNDERRUN <= 1'b0;
        end else if (ABORT) begin
            state_q  <= StIdle;
            first_q  <= 1'b0;
            FIFO_RE  <= 1'b0;
            GLITCH   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            FIFO_RE  <= 1'b0;
            DONE     <= 1'b0;
            UNDERRUN <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ARM) begin
                        if (FIFO_EMPTY) begin
                            UNDERRUN <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                            FIFO_RE <= 1'b1;
                            BUSY    <= 1'b1;
                            first_q <= 1'b1;
                        end
                    end
                end
                StFetch: state_q <= StLoad;
                StLoad: begin
                    desc_q <= desc_t'(FIFO_Q);
                    if (first_q) begin
                        state_q <= StWaitTrig;
                    end else begin
                        state_q <= StDelay;
                        cnt_q   <= fifo_delay;
                    end
                end
                StWaitTrig: begin
                    if (trig_pulse) begin
                        state_q <= StDelay;
                        cnt_q   <= desc_delay;
                        first_q <= 1'b0;
                    end
                end
                StDelay: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end else if (desc_width != '0) begin
                        state_q <= StPulse;
                        cnt_q   <= DELAY_W'(desc_width) - DELAY_W'(1);
                        GLITCH  <= 1'b1;
                    end
                end
                StPulse: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (seq_end) begin
                GLITCH <= 1'b0;
                if (desc_q.last) begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b1;
                end else if (FIFO_EMPTY) begin
                    state_q  <= StIdle;
                    BUSY     <= 1'b0;
                    UNDERRUN <= 1'b1;
                end else begin
                    state_q <= StFetch;
                    FIFO_RE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_glitch_player.sv
// Self-checking bench for glitch_player: FIFO model plus a timeline reference
// built from descriptor delay/width arithmetic.
module tb_glitch_player;

`ifdef GLITCH_TRIG_SYNC_EN
    localparam int TL = 3;
`else
    localparam int TL = 1;
`endif
    localparam int MAXC = 512;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        ARM = 1'b0;
    logic        TRIGGER = 1'b0;
    logic        ABORT = 1'b0;
    logic [31:0] FIFO_Q = '0;
    logic        FIFO_EMPTY = 1'b1;
    logic        FIFO_RE;
    logic        GLITCH;
    logic        BUSY;
    logic        DONE;
    logic        UNDERRUN;

    int checks = 0;
    int failures = 0;

    logic [31:0] fifo[$];
    bit exp_g[MAXC];
    bit exp_done[MAXC];
    bit exp_und[MAXC];
    bit exp_re[MAXC];
    bit exp_busy[MAXC];

    glitch_player dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ARM        (ARM),
        .TRIGGER    (TRIGGER),
        .ABORT      (ABORT),
        .FIFO_Q     (FIFO_Q),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RE    (FIFO_RE),
        .GLITCH     (GLITCH),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .UNDERRUN   (UNDERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] mk(input int d, input int w, input bit l);
        logic [15:0] dd;
        logic [14:0] ww;
        dd = d[15:0];
        ww = w[14:0];
        return {dd, ww, l};
    endfunction

    // FIFO acts on the falling edge, then outputs are sampled 1 unit after the rising edge.
    task automatic tick();
        @(negedge CLOCK);
        if (FIFO_RE && fifo.size() > 0) FIFO_Q = fifo.pop_front();
        FIFO_EMPTY = (fifo.size() == 0);
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        fifo.push_back(d);
        FIFO_EMPTY = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit g, input bit dn, input bit un,
                            input bit re, input bit bz);
        chk({tag, ".glitch"}, {31'd0, GLITCH}, {31'd0, g});
        chk({tag, ".done"}, {31'd0, DONE}, {31'd0, dn});
        chk({tag, ".underrun"}, {31'd0, UNDERRUN}, {31'd0, un});
        chk({tag, ".fifo_re"}, {31'd0, FIFO_RE}, {31'd0, re});
        chk({tag, ".busy"}, {31'd0, BUSY}, {31'd0, bz});
    endtask

    // Arm at edge 0, raise the trigger at edge t, compare every edge to the timeline.
    task automatic arm_and_check(input string name, input int gap, input bit held);
        logic [31:0] snap[$];
        logic [31:0] dsc;
        int t, te, e, start, d, w;
        bit more, first;
        for (int k = 0; k < MAXC; k++) begin
            exp_g[k] = 0; exp_done[k] = 0; exp_und[k] = 0; exp_re[k] = 0; exp_busy[k] = 0;
        end
        snap = fifo;
        t = held ? 4 + gap : 3 + gap;
        te = t + TL - 1;
        exp_re[0] = 1;
        e = 0;
        first = 1;
        more = 1;
        while (more && snap.size() > 0) begin
            dsc = snap.pop_front();
            d = int'(dsc[31:16]);
            w = int'(dsc[15:1]);
            if (first) begin
                start = te + d + 1;
            end else begin
                exp_re[e] = 1;
                start = e + d + 3;
            end
            first = 0;
            for (int k = start; k < start + w && k < MAXC; k++) exp_g[k] = 1;
            e = start + w;
            if (dsc[0]) begin
                exp_done[e] = 1;
                more = 0;
            end else if (snap.size() == 0) begin
                exp_und[e] = 1;
                more = 0;
            end
        end
        for (int k = 0; k < e; k++) exp_busy[k] = 1;
        if (held) begin
            TRIGGER = 1'b1;
            tick();
            tick();
        end
        for (int k = 0; k <= e + 2; k++) begin
            ARM = (k == 0);
            if (held && k < 3) TRIGGER = 1'b1;
            else TRIGGER = (k >= t);
            tick();
            chk_outs($sformatf("%s@%0d", name, k), exp_g[k], exp_done[k], exp_und[k],
                     exp_re[k], exp_busy[k]);
        end
        ARM = 1'b0;
        TRIGGER = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int n, t, te, start;
        bit l;

        // Reset state
        tick();
        tick();
        chk_outs("reset", 0, 0, 0, 0, 0);
        RESET = 1'b0;
        repeat (3) tick();
        chk_outs("post_reset_idle", 0, 0, 0, 0, 0);

        // Directed cases
        push(mk(5, 3, 1));
        arm_and_check("single", 2, 0);
        push(mk(0, 2, 0));
        push(mk(4, 1, 1));
        arm_and_check("two", 0, 0);
        push(mk(3, 0, 1));
        arm_and_check("zero_w", 1, 0);
        push(mk(2, 2, 0));
        arm_and_check("underrun", 1, 0);
        push(mk(1, 2, 1));
        arm_and_check("held_trig", 2, 1);

        // ARM with empty FIFO
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        chk_outs("arm_empty", 0, 0, 1, 0, 0);
        tick();
        chk_outs("arm_empty_next", 0, 0, 0, 0, 0);

        // Simultaneous ARM and ABORT in IDLE: nothing fetched
        push(mk(2, 100, 1));
        push(mk(1, 2, 1));
        ARM = 1'b1;
        ABORT = 1'b1;
        tick();
        ARM = 1'b0;
        ABORT = 1'b0;
        chk_outs("arm_abort", 0, 0, 0, 0, 0);
        tick();
        chk_outs("arm_abort_next", 0, 0, 0, 0, 0);
        chk("arm_abort_fifo_level", fifo.size(), 2);

        // Abort mid-pulse of the long descriptor
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        tick();
        tick();
        TRIGGER = 1'b1;
        tick();
        t = 3;
        te = t + TL - 1;
        start = te + 2 + 1;
        for (int k = t + 1; k <= start + 10; k++) tick();
        chk_outs("abort_pre", 1, 0, 0, 0, 1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk_outs("abort_edge", 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_outs($sformatf("abort_after%0d", k), 0, 0, 0, 0, 0);
        end
        TRIGGER = 1'b0;
        repeat (3) tick();
        arm_and_check("abort_next", 1, 0);

        // Randomized sequences
        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < n; j++) begin
                l = (j == n - 1) ? bit'($urandom_range(0, 1)) : 1'b0;
                push(mk(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), l));
            end
            arm_and_check($sformatf("rnd%0d", i), int'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
